// File: rtl/bfu_pkg.sv
// Shared types and constants for the NTT/INTT butterfly unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents: operation mode enum, ML-DSA and Kyber modulus constants,
// and the default-width pipeline stage record. Defining BFU_FINAL_REDUCE_EN
// adds a canonicalising output stage, which is reflected in BFU_LAT.
package bfu_pkg;

    typedef enum logic [1:0] {
        MODE_NTT  = 2'd0,   // Cooley-Tukey: (a + Mont(b*tw), a - Mont(b*tw))
        MODE_INTT = 2'd1,   // Gentleman-Sande: (a + b, Mont((b - a)*tw))
        MODE_PASS = 2'd2,   // operands unchanged, same latency
        MODE_MUL  = 2'd3    // pointwise: (Mont(a*tw), Mont(b*tw))
    } bfu_mode_e;

    // ML-DSA: Q = 8380417, QINV = Q^-1 mod 2^32
    localparam int MLDSA_Q    = 8380417;
    localparam int MLDSA_QINV = 58728449;

    // Kyber: Q = 3329, QINV = Q^-1 mod 2^16 (signed representative)
    localparam int KYBER_Q    = 3329;
    localparam int KYBER_QINV = -3327;

    localparam int BFU_WIDTH = 32;
    localparam int BFU_TAG_W = 8;

`ifdef BFU_FINAL_REDUCE_EN
    localparam int BFU_LAT = 5;
`else
    localparam int BFU_LAT = 4;
`endif

    // One pipeline stage at the default widths; the top re-declares the same
    // layout locally so that it follows its WIDTH/TAG_W parameters.
    typedef struct packed {
        logic                 vld;
        bfu_mode_e            mode;
        logic [BFU_WIDTH-1:0] a;
        logic [BFU_WIDTH-1:0] b;
        logic [BFU_TAG_W-1:0] tag;
    } bfu_stage_t;

endpackage

// File: rtl/bfu_pipe_mont_reduce.sv
// Pipelined signed Montgomery reduction: r = p * 2^-WIDTH mod Q, r in (-Q,Q).
// Latency: 2 register stages (p, then p with t); r is combinational off stage 2.
// Backpressure: both stages hold while en=0, in lock-step with the caller.
//
// Ports: clk, rst_n (async active-low), en (advance), p (2*WIDTH signed
// product), r (WIDTH signed result aligned with the caller's second stage).
module mont_reduce #(
    parameter int WIDTH = 32,
    parameter int Q     = 8380417,
    parameter int QINV  = 58728449
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic signed [2*WIDTH-1:0] p,
    output logic signed [WIDTH-1:0]   r
);

    localparam logic signed [WIDTH-1:0]   QINV_W = WIDTH'(QINV);
    localparam logic signed [2*WIDTH-1:0] Q_X    = (2*WIDTH)'(Q);

    logic signed [2*WIDTH-1:0] p1_q;
    logic signed [2*WIDTH-1:0] p2_q;
    logic signed [WIDTH-1:0]   p1_lo;
    logic signed [WIDTH-1:0]   t_d;
    logic signed [WIDTH-1:0]   t_q;
    logic signed [2*WIDTH-1:0] t_x;
    logic signed [2*WIDTH-1:0] diff;
    logic                      unused_diff_lo;

    // t = low half of p*QINV; only the low half of p influences it.
    assign p1_lo = p1_q[WIDTH-1:0];
    assign t_d   = p1_lo * QINV_W;

    // p - t*Q is an exact multiple of 2^WIDTH, so the high half is the
    // arithmetic shift and the low half is always zero.
    assign t_x            = {{WIDTH{t_q[WIDTH-1]}}, t_q};
    assign diff           = p2_q - t_x * Q_X;
    assign r              = diff[2*WIDTH-1:WIDTH];
    assign unused_diff_lo = ^diff[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q <= '0;
            p2_q <= '0;
            t_q  <= '0;
        end else if (en) begin
            p1_q <= p;
            p2_q <= p1_q;
            t_q  <= t_d;
        end
    end

endmodule

// File: rtl/bfu_pipe.sv
// Pipelined NTT/INTT/PASS/MUL butterfly for the ML-DSA coefficient datapath.
// Latency: 4 cycles accept-to-o_valid (5 with BFU_FINAL_REDUCE_EN), 1 op/cycle.
// Backpressure: single global advance en = ~o_valid | i_ready; all stages freeze when en=0.
//
// Ports: i_clk, i_rst_n (async active-low); input side i_valid/o_in_ready with
// i_mode, i_a, i_b, i_twiddle, i_tag; output side o_valid/i_ready with o_a, o_b,
// o_tag; o_busy is high while any stage holds a valid operation.
// Build option: define BFU_FINAL_REDUCE_EN to add a stage mapping o_a/o_b into [0,Q).
module bfu_pipe
    import bfu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int Q     = MLDSA_Q,
    parameter int QINV  = MLDSA_QINV,
    parameter int TAG_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_in_ready,
    input  logic [1:0]              i_mode,
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    input  logic signed [WIDTH-1:0] i_twiddle,
    input  logic [TAG_W-1:0]        i_tag,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [WIDTH-1:0] o_a,
    output logic signed [WIDTH-1:0] o_b,
    output logic [TAG_W-1:0]        o_tag,
    output logic                    o_busy
);

    localparam logic signed [WIDTH-1:0] QW = WIDTH'(Q);

    typedef struct packed {
        logic             vld;
        bfu_mode_e        mode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } stage_t;

    function automatic logic signed [2*WIDTH-1:0] sext(input logic [WIDTH-1:0] x);
        return {{WIDTH{x[WIDTH-1]}}, x};
    endfunction

    logic en;

    stage_t s0_q, s0_d;
    stage_t s1_q, s1_d;
    stage_t s2_q, s2_d;
    stage_t s3_q, s3_d;
    logic [WIDTH-1:0] tw0_q;

    logic signed [2*WIDTH-1:0] prod_a;
    logic signed [2*WIDTH-1:0] prod_b;
    logic signed [WIDTH-1:0]   r_a;
    logic signed [WIDTH-1:0]   r_b;

    assign o_in_ready = en;

    // ---------------------------------------------------------------- S0
    // INTT butterfly additions happen on capture so S1 only has to reduce.
    always_comb begin
        s0_d     = s0_q;
        s0_d.vld = i_valid;
        if (i_valid) begin
            s0_d.mode = bfu_mode_e'(i_mode);
            s0_d.tag  = i_tag;
            if (bfu_mode_e'(i_mode) == MODE_INTT) begin
                s0_d.a = i_a + i_b;
                s0_d.b = i_b - i_a;
            end else begin
                s0_d.a = i_a;
                s0_d.b = i_b;
            end
        end
    end

    // Both products are formed every cycle; the a-path result is only
    // consumed by MUL, everything else uses a from the stage record.
    assign prod_b = sext(s0_q.b) * sext(tw0_q);
    assign prod_a = sext(s0_q.a) * sext(tw0_q);

    mont_reduce #(.WIDTH(WIDTH), .Q(Q), .QINV(QINV)) u_mont_b (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (en),
        .p     (prod_b),
        .r     (r_b)
    );

    mont_reduce #(.WIDTH(WIDTH), .Q(Q), .QINV(QINV)) u_mont_a (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (en),
        .p     (prod_a),
        .r     (r_a)
    );

    // ---------------------------------------------------------------- S1
    // a + b lies in (-2Q, 2Q); the two one-sided corrections in S1 and S2
    // bring it into (-Q, Q).
    always_comb begin
        s1_d = s0_q;
        if (s0_q.mode == MODE_INTT && $signed(s0_q.a) >= QW) begin
            s1_d.a = s0_q.a - QW;
        end
    end

    // ---------------------------------------------------------------- S2
    always_comb begin
        s2_d = s1_q;
        if (s1_q.mode == MODE_INTT && $signed(s1_q.a) <= -QW) begin
            s2_d.a = s1_q.a + QW;
        end
    end

    // ---------------------------------------------------------------- S3
    // Data only updates on a valid operation so bubbles leave the last
    // result on the output bus.
    always_comb begin
        s3_d     = s3_q;
        s3_d.vld = s2_q.vld;
        if (s2_q.vld) begin
            s3_d.mode = s2_q.mode;
            s3_d.tag  = s2_q.tag;
            case (s2_q.mode)
                MODE_NTT: begin
                    s3_d.a = s2_q.a + r_b;
                    s3_d.b = s2_q.a - r_b;
                end
                MODE_INTT: begin
                    s3_d.a = s2_q.a;
                    s3_d.b = r_b;
                end
                MODE_PASS: begin
                    s3_d.a = s2_q.a;
                    s3_d.b = s2_q.b;
                end
                MODE_MUL: begin
                    s3_d.a = r_a;
                    s3_d.b = r_b;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s0_q  <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            tw0_q <= '0;
        end else if (en) begin
            s0_q <= s0_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
            if (i_valid) begin
                tw0_q <= i_twiddle;
            end
        end
    end

`ifdef BFU_FINAL_REDUCE_EN
    // ---------------------------------------------------------------- S4
    // Inputs lie in (-2Q, 2Q): at most two additions or two subtractions.
    function automatic logic [WIDTH-1:0] canon(input logic [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] y;
        y = x;
        if (y[WIDTH-1]) y = y + QW;
        if (y[WIDTH-1]) y = y + QW;
        if (y >= QW)    y = y - QW;
        if (y >= QW)    y = y - QW;
        return y;
    endfunction

    stage_t s4_q, s4_d;

    always_comb begin
        s4_d     = s4_q;
        s4_d.vld = s3_q.vld;
        if (s3_q.vld) begin
            s4_d.mode = s3_q.mode;
            s4_d.tag  = s3_q.tag;
            s4_d.a    = canon(s3_q.a);
            s4_d.b    = canon(s3_q.b);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s4_q <= '0;
        end else if (en) begin
            s4_q <= s4_d;
        end
    end

    assign o_valid = s4_q.vld;
    assign o_a     = s4_q.a;
    assign o_b     = s4_q.b;
    assign o_tag   = s4_q.tag;
    assign o_busy  = s0_q.vld | s1_q.vld | s2_q.vld | s3_q.vld | s4_q.vld;
`else
    assign o_valid = s3_q.vld;
    assign o_a     = s3_q.a;
    assign o_b     = s3_q.b;
    assign o_tag   = s3_q.tag;
    assign o_busy  = s0_q.vld | s1_q.vld | s2_q.vld | s3_q.vld;
`endif

    assign en = ~o_valid | i_ready;

endmodule

// File: tb/tb_bfu_pipe.sv
// Directed self-checking bench for bfu_pipe: hand-computed butterfly results,
// latency, stall/drain ordering, reset flush and the optional final reduction.
module tb_bfu_pipe;

    localparam int Q = 8380417;
`ifdef BFU_FINAL_REDUCE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_in_ready;
    logic [1:0]  i_mode;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [31:0] i_twiddle;
    logic [7:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_a;
    logic [31:0] o_b;
    logic [7:0]  o_tag;
    logic        o_busy;

    bfu_pipe dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_in_ready (o_in_ready),
        .i_mode     (i_mode),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_twiddle  (i_twiddle),
        .i_tag      (i_tag),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_a        (o_a),
        .o_b        (o_b),
        .o_tag      (o_tag),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_cnt = 0;

    typedef struct { int a; int b; int tag; int cyc; } obs_t;
    typedef struct { int a; int b; int tag; } exp_t;
    obs_t obs_q[$];
    exp_t exp_q[$];
    obs_t mon_e;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", name,
                     $signed(got), got, $signed(want), want);
        end
    endtask

    function automatic int exp_out(input int x);
`ifdef BFU_FINAL_REDUCE_EN
        int y;
        y = x % Q;
        if (y < 0) y = y + Q;
        return y;
`else
        return x;
`endif
    endfunction

    always @(posedge clk) cyc++;

    // Output handshakes and input accepts, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            mon_e.a   = $signed(o_a);
            mon_e.b   = $signed(o_b);
            mon_e.tag = int'(o_tag);
            mon_e.cyc = cyc;
            obs_q.push_back(mon_e);
        end
        if (rst_n && i_valid && o_in_ready) acc_cnt++;
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [1:0] m, input int a, input int b, input int tw,
                        input logic [7:0] tg, input int ea, input int eb);
        int   guard;
        bit   done;
        exp_t e;
        i_valid = 1'b1; i_mode = m; i_a = a; i_b = b; i_twiddle = tw; i_tag = tg;
        e.a = exp_out(ea); e.b = exp_out(eb); e.tag = int'(tg);
        exp_q.push_back(e);
        guard = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (o_in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 200) begin
                    chk("send_timeout", {31'd0, o_in_ready}, 32'd1);
                    done = 1'b1;
                end
            end
        end
        #1 i_valid = 1'b0;
    endtask

    task automatic wait_obs(input string name, input int n);
        int guard;
        guard = 0;
        while (obs_q.size() < n && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (obs_q.size() < n) chk(name, obs_q.size(), n);
    endtask

    task automatic check_stream(input string name);
        int n;
        n = exp_q.size();
        wait_obs({name, "_timeout"}, n);
        repeat (3) @(posedge clk);
        chk({name, "_count"}, obs_q.size(), n);
        for (int k = 0; k < n && k < obs_q.size(); k++) begin
            chk($sformatf("%s_a%0d", name, k),   obs_q[k].a,   exp_q[k].a);
            chk($sformatf("%s_b%0d", name, k),   obs_q[k].b,   exp_q[k].b);
            chk($sformatf("%s_tag%0d", name, k), obs_q[k].tag, exp_q[k].tag);
            if (k > 0) chk($sformatf("%s_gap%0d", name, k), obs_q[k].cyc - obs_q[k-1].cyc, 1);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    bit sender_done;
    int n_lat;
    int acc0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_mode = 2'd0; i_a = '0; i_b = '0; i_twiddle = '0; i_tag = '0;
        sender_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // ---- reset state
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_a",     o_a, 32'd0);
        chk("rst_b",     o_b, 32'd0);
        chk("rst_tag",   {24'd0, o_tag}, 32'd0);
        chk("rst_busy",  {31'd0, o_busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'd0, o_in_ready}, 32'd1);

        // ---- Test 1: NTT latency and result
        send(2'd0, 10, 65536, 196608, 8'h11, 13, 7);
        n_lat = 1;
        @(negedge clk);
        while (!o_valid && n_lat < 20) begin
            @(posedge clk);
            n_lat++;
            @(negedge clk);
        end
        chk("t1_latency", n_lat, LAT);
        chk("t1_a",   o_a, exp_out(13));
        chk("t1_b",   o_b, exp_out(7));
        chk("t1_tag", {24'd0, o_tag}, 32'h11);
        @(negedge clk);
        chk("t1_valid_drop", {31'd0, o_valid}, 32'd0);
        chk("t1_busy_drop",  {31'd0, o_busy}, 32'd0);
        @(posedge clk); #1;
        obs_q.delete();
        exp_q.delete();

        // ---- Tests 2/3: mixed modes back-to-back, plus INTT reduction edges
        send(2'd1, 3, 65539, 65536,  8'h21, 65542, 1);
        send(2'd1, Q-1, Q, 0,        8'h22, Q-1, 0);
        send(2'd2, -7, 9, 12345,     8'h23, -7, 9);
        send(2'd3, 65536, 131072, 65536, 8'h24, 1, 2);
        send(2'd0, 0, 65536, 65536,  8'h25, 1, -1);
        send(2'd1, -Q, -1, 0,        8'h26, -1, 0);
        send(2'd1, 1, Q-1, 0,        8'h27, 0, 0);
        send(2'd0, 5, 65536, -65536, 8'h28, 4, 6);
        check_stream("mix");

        // ---- Test 4: stall with 6 ops, then drain
        @(posedge clk); #1;
        i_ready = 1'b0;
        acc0 = acc_cnt;
        fork
            begin
                send(2'd2, 101, 201, 0,        8'h41, 101, 201);
                send(2'd2, 102, 202, 0,        8'h42, 102, 202);
                send(2'd0, 10, 65536, 196608,  8'h43, 13, 7);
                send(2'd3, 65536, 131072, 65536, 8'h44, 1, 2);
                send(2'd2, 105, 205, 0,        8'h45, 105, 205);
                send(2'd1, 3, 65539, 65536,    8'h46, 65542, 1);
                sender_done = 1'b1;
            end
        join_none
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!o_in_ready) break;
        end
        chk("stall_in_ready", {31'd0, o_in_ready}, 32'd0);
        chk("stall_accepts",  acc_cnt - acc0, LAT);
        for (int k = 0; k < 4; k++) begin
            chk("stall_valid", {31'd0, o_valid}, 32'd1);
            chk("stall_hold_a", o_a, exp_out(101));
            chk("stall_hold_b", o_b, exp_out(201));
            chk("stall_hold_tag", {24'd0, o_tag}, 32'h41);
            @(negedge clk);
        end
        chk("stall_no_output", obs_q.size(), 0);
        @(posedge clk); #1;
        i_ready = 1'b1;
        wait_obs("drain_timeout", 6);
        @(negedge clk);
        chk("drain_busy",  {31'd0, o_busy}, 32'd0);
        chk("drain_valid", {31'd0, o_valid}, 32'd0);
        chk("drain_sender", {31'd0, sender_done}, 32'd1);
        chk("drain_accepts", acc_cnt - acc0, 6);
        check_stream("drain");

        // ---- Test 5: reset with 3 ops in flight
        @(posedge clk); #1;
        send(2'd2, 7, 8, 0, 8'h51, 7, 8);
        send(2'd2, 9, 10, 0, 8'h52, 9, 10);
        send(2'd2, 11, 12, 0, 8'h53, 11, 12);
        chk("inflight_busy", {31'd0, o_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, o_valid}, 32'd0);
        chk("mrst_a",     o_a, 32'd0);
        chk("mrst_b",     o_b, 32'd0);
        chk("mrst_tag",   {24'd0, o_tag}, 32'd0);
        chk("mrst_busy",  {31'd0, o_busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        repeat (10) @(posedge clk);
        #1;
        chk("mrst_no_stale", obs_q.size(), 0);
        chk("mrst_busy_after", {31'd0, o_busy}, 32'd0);

`ifdef BFU_FINAL_REDUCE_EN
        // ---- Test 6: canonical output range
        send(2'd0, 0, 65536, 65536, 8'h61, 1, Q-1);
        check_stream("final");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
